// File: rtl/operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// operand_sequencer_pkg
// Shared types and constants for the operand sequencer:
//   - DATA_W     : operand / result bus width
//   - IDX_A..X   : operand index values, presented to the evaluator in this order
//   - state_e    : sequencer state encoding
//   - min_one    : maps a zero phase length to one cycle
//   - sel_operand: picks the latched operand addressed by an index
// -----------------------------------------------------------------------------
package operand_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_X = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_GO_HI      = 3'd2,
    ST_GO_LO      = 3'd3,
    ST_WAIT_VALID = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // A phase length of zero still occupies one cycle.
  function automatic int min_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [1:0]        idx,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] v;
    case (idx)
      IDX_A:   v = a;
      IDX_B:   v = b;
      IDX_C:   v = c;
      IDX_X:   v = x;
      default: v = {DATA_W{1'b0}};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// operand_sequencer_if
// Bundles the host request side and the evaluator handshake side.
//   Host side     : start, coef_a/b/c/x in; busy, done, result, error out
//   Evaluator side: go, data_out out; data_result, result_valid in
// master = the sequencer, slave = its environment (host + evaluator).
// -----------------------------------------------------------------------------
interface operand_sequencer_if;
  import operand_sequencer_pkg::*;

  logic              start;
  logic [DATA_W-1:0] coef_a;
  logic [DATA_W-1:0] coef_b;
  logic [DATA_W-1:0] coef_c;
  logic [DATA_W-1:0] coef_x;
  logic              go;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_result;
  logic              result_valid;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              error;

  modport master (
    input  start, coef_a, coef_b, coef_c, coef_x, data_result, result_valid,
    output go, data_out, busy, done, result, error
  );

  modport slave (
    output start, coef_a, coef_b, coef_c, coef_x, data_result, result_valid,
    input  go, data_out, busy, done, result, error
  );

endinterface

// File: rtl/operand_sequencer_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter with a terminal flag.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : load load_val this cycle (takes priority over counting)
//   load_val    : value loaded; a phase of N cycles is loaded with N-1
//   tc          : count has reached zero (counter then holds at zero)
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Load on request, otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
// Presents four latched operands (A, B, C, X) to a polynomial evaluator using
// a Go strobe, then captures the evaluator result.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : operand_sequencer_if.master (start/coefs in, go/data_out to the
//            evaluator, data_result/result_valid back, busy/done/result/error)
// Parameters: SETUP_CYCLES, GO_HIGH_CYCLES, GO_LOW_CYCLES (0 treated as 1),
//             TIMEOUT_CYCLES (only meaningful with the macro below).
// Build option: define OPERAND_SEQUENCER_TIMEOUT_EN to bound the wait for
//   result_valid; on expiry error is set (sticky until reset or next accepted
//   start) and the sequencer returns to idle without done. Without the macro
//   the wait is unbounded and error is tied low.
// -----------------------------------------------------------------------------
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int SETUP_CYCLES   = 2,
  parameter int GO_HIGH_CYCLES = 3,
  parameter int GO_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                resetn,
  operand_sequencer_if.master bus
);

  localparam int SU_N  = min_one(SETUP_CYCLES);
  localparam int HI_N  = min_one(GO_HIGH_CYCLES);
  localparam int LO_N  = min_one(GO_LOW_CYCLES);
  localparam int TO_N  = min_one(TIMEOUT_CYCLES);
  localparam int MAX_A = (SU_N > HI_N) ? SU_N : HI_N;
  localparam int MAX_B = (LO_N > TO_N) ? LO_N : TO_N;
  localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  // Timer is loaded with length-1 so tc marks the last cycle of a phase.
  localparam logic [TW-1:0] SU_LD = TW'(SU_N - 1);
  localparam logic [TW-1:0] HI_LD = TW'(HI_N - 1);
  localparam logic [TW-1:0] LO_LD = TW'(LO_N - 1);
  localparam logic [TW-1:0] TO_LD = TW'(TO_N - 1);

  state_e            state_r;
  logic [1:0]        idx_r;
  logic [DATA_W-1:0] coef_a_r;
  logic [DATA_W-1:0] coef_b_r;
  logic [DATA_W-1:0] coef_c_r;
  logic [DATA_W-1:0] coef_x_r;
  logic              go_r;
  logic [DATA_W-1:0] data_out_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] result_r;
  logic              tmr_load_s;
  logic [TW-1:0]     tmr_val_s;
  logic              tmr_tc_s;

  phase_timer #(.W(TW)) u_phase_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Reload the timer on the same edge the FSM enters a timed phase.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = SU_LD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tmr_tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = HI_LD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_GO_HI: begin
        if (tmr_tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = LO_LD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_GO_LO: begin
        if (tmr_tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = (idx_r == IDX_X) ? TO_LD : SU_LD;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {TW{1'b0}};
      end
    endcase
  end

`ifdef OPERAND_SEQUENCER_TIMEOUT_EN
  logic error_r;
  assign bus.error = error_r;
`else
  assign bus.error = 1'b0;
`endif

  // Sequencer FSM; go/data_out/busy/done/result are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      idx_r      <= IDX_A;
      coef_a_r   <= {DATA_W{1'b0}};
      coef_b_r   <= {DATA_W{1'b0}};
      coef_c_r   <= {DATA_W{1'b0}};
      coef_x_r   <= {DATA_W{1'b0}};
      go_r       <= 1'b0;
      data_out_r <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {DATA_W{1'b0}};
`ifdef OPERAND_SEQUENCER_TIMEOUT_EN
      error_r    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            coef_a_r   <= bus.coef_a;
            coef_b_r   <= bus.coef_b;
            coef_c_r   <= bus.coef_c;
            coef_x_r   <= bus.coef_x;
            idx_r      <= IDX_A;
            data_out_r <= bus.coef_a;
            busy_r     <= 1'b1;
            state_r    <= ST_SETUP;
`ifdef OPERAND_SEQUENCER_TIMEOUT_EN
            error_r    <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (tmr_tc_s) begin
            go_r    <= 1'b1;
            state_r <= ST_GO_HI;
          end
        end
        ST_GO_HI: begin
          if (tmr_tc_s) begin
            go_r    <= 1'b0;
            state_r <= ST_GO_LO;
          end
        end
        ST_GO_LO: begin
          if (tmr_tc_s) begin
            if (idx_r == IDX_X) begin
              state_r <= ST_WAIT_VALID;
            end else begin
              idx_r      <= idx_r + 2'd1;
              data_out_r <= sel_operand(idx_r + 2'd1, coef_a_r, coef_b_r,
                                        coef_c_r, coef_x_r);
              state_r    <= ST_SETUP;
            end
          end
        end
        ST_WAIT_VALID: begin
          if (bus.result_valid) begin
            result_r <= bus.data_result;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
`ifdef OPERAND_SEQUENCER_TIMEOUT_EN
          else if (tmr_tc_s) begin
            error_r    <= 1'b1;
            busy_r     <= 1'b0;
            data_out_r <= {DATA_W{1'b0}};
            state_r    <= ST_IDLE;
          end
`endif
        end
        ST_DONE: begin
          busy_r     <= 1'b0;
          data_out_r <= {DATA_W{1'b0}};
          state_r    <= ST_IDLE;
        end
        default: begin
          go_r       <= 1'b0;
          busy_r     <= 1'b0;
          data_out_r <= {DATA_W{1'b0}};
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.go       = go_r;
  assign bus.data_out = data_out_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
  import operand_sequencer_pkg::*;

  localparam int S   = 2;
  localparam int H   = 3;
  localparam int L   = 2;
  localparam int PER = S + H + L;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   go_rises = 0;
  logic go_prev  = 1'b0;
  logic [7:0] ops [4];

  operand_sequencer_if intf();

  operand_sequencer #(
    .SETUP_CYCLES   (S),
    .GO_HIGH_CYCLES (H),
    .GO_LOW_CYCLES  (L),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (intf)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (intf.go && !go_prev) go_rises++;
    go_prev = intf.go;
  endtask

  task automatic start_seq(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] x);
    intf.coef_a = a;
    intf.coef_b = b;
    intf.coef_c = c;
    intf.coef_x = x;
    intf.start  = 1'b1;
    cyc = 0;
    tick();
    intf.start = 1'b0;
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    resetn            = 1'b0;
    intf.start        = 1'b0;
    intf.coef_a       = 8'h00;
    intf.coef_b       = 8'h00;
    intf.coef_c       = 8'h00;
    intf.coef_x       = 8'h00;
    intf.data_result  = 8'h00;
    intf.result_valid = 1'b0;
    tick();
    tick();
    chk1("rst_go", intf.go, 1'b0);
    chk8("rst_dout", intf.data_out, 8'h00);
    chk1("rst_busy", intf.busy, 1'b0);
    chk1("rst_done", intf.done, 1'b0);
    chk8("rst_result", intf.result, 8'h00);
    chk1("rst_error", intf.error, 1'b0);
    resetn = 1'b1;
    tick();

    // result_valid while idle must be ignored
    intf.result_valid = 1'b1;
    intf.data_result  = 8'h99;
    tick();
    tick();
    chk8("idle_rv_result", intf.result, 8'h00);
    chk1("idle_rv_done", intf.done, 1'b0);
    chk1("idle_rv_busy", intf.busy, 1'b0);
    intf.result_valid = 1'b0;
    tick();

    // Main sequence A=2,B=3,C=4,X=5 with a spurious start (A=FF) during the
    // second Go pulse and a result_valid pulse during the first Go pulse.
    ops = '{8'h02, 8'h03, 8'h04, 8'h05};
    go_rises = 0;
    start_seq(8'h02, 8'h03, 8'h04, 8'h05);
    for (int c = 1; c <= 4 * PER; c++) begin
      int k;
      int p;
      k = (c - 1) / PER;
      p = (c - 1) % PER;
      chk1("seq_go", intf.go, (p >= S) && (p < S + H));
      chk8("seq_dout", intf.data_out, ops[k]);
      chk1("seq_busy", intf.busy, 1'b1);
      chk1("seq_done", intf.done, 1'b0);
      chk8("seq_result", intf.result, 8'h00);
      intf.result_valid = (c == S + 2);
      intf.data_result  = 8'h77;
      if (c == PER + S + 1) begin
        intf.start  = 1'b1;
        intf.coef_a = 8'hFF;
      end
      if (c == PER + S + 3) intf.start = 1'b0;
      tick();
    end
    intf.result_valid = 1'b0;
    chki("seq_go_count", go_rises, 4);
    chk1("wait_busy", intf.busy, 1'b1);
    chk1("wait_go", intf.go, 1'b0);
    tick();
    tick();
    tick();
    chk8("wait_result", intf.result, 8'h00);
    intf.result_valid = 1'b1;
    intf.data_result  = 8'h45;
    tick();
    intf.result_valid = 1'b0;
    chk1("done_pulse", intf.done, 1'b1);
    chk8("done_result", intf.result, 8'h45);
    chk1("done_busy", intf.busy, 1'b1);
    tick();
    chk1("post_done", intf.done, 1'b0);
    chk1("post_busy", intf.busy, 1'b0);
    chk8("post_dout", intf.data_out, 8'h00);
    chk8("post_result", intf.result, 8'h45);
    tick();
    chk1("no_queue_busy", intf.busy, 1'b0);
    chk1("no_queue_go", intf.go, 1'b0);

    // Reset during the third Go pulse
    start_seq(8'h11, 8'h22, 8'h33, 8'h44);
    adv_to(2 * PER + S + 2);
    chk1("third_go", intf.go, 1'b1);
    chk8("third_dout", intf.data_out, 8'h33);
    #2;
    resetn = 1'b0;
    #1;
    chk1("abort_go", intf.go, 1'b0);
    chk1("abort_busy", intf.busy, 1'b0);
    chk8("abort_dout", intf.data_out, 8'h00);
    chk8("abort_result", intf.result, 8'h00);
    tick();
    tick();
    resetn   = 1'b1;
    go_rises = 0;
    repeat (30) tick();
    chki("abort_no_pulses", go_rises, 0);
    chk1("abort_idle", intf.busy, 1'b0);

    // Restart from A
    start_seq(8'h11, 8'h22, 8'h33, 8'h44);
    chk8("restart_dout", intf.data_out, 8'h11);
    chk1("restart_go", intf.go, 1'b0);
    chk1("restart_busy", intf.busy, 1'b1);
    adv_to(S + 1);
    chk1("restart_go_hi", intf.go, 1'b1);
    chk8("restart_dout_hi", intf.data_out, 8'h11);
    adv_to(4 * PER + 1);

`ifdef OPERAND_SEQUENCER_TIMEOUT_EN
    adv_to(4 * PER + TO);
    chk1("to_pre_error", intf.error, 1'b0);
    chk1("to_pre_busy", intf.busy, 1'b1);
    tick();
    chk1("to_error", intf.error, 1'b1);
    chk1("to_busy", intf.busy, 1'b0);
    chk1("to_done", intf.done, 1'b0);
    chk8("to_result", intf.result, 8'h00);
    chk8("to_dout", intf.data_out, 8'h00);
    tick();
    chk1("to_error_sticky", intf.error, 1'b1);
    chk1("to_no_done", intf.done, 1'b0);
    start_seq(8'h01, 8'h02, 8'h03, 8'h04);
    chk1("to_error_clr", intf.error, 1'b0);
    adv_to(4 * PER + 1);
`else
    adv_to(4 * PER + TO + 5);
    chk1("nto_busy", intf.busy, 1'b1);
    chk1("nto_error", intf.error, 1'b0);
`endif
    intf.result_valid = 1'b1;
    intf.data_result  = 8'h5A;
    tick();
    intf.result_valid = 1'b0;
    chk1("final_done", intf.done, 1'b1);
    chk8("final_result", intf.result, 8'h5A);
    tick();
    chk1("final_busy", intf.busy, 1'b0);
    chk1("final_error", intf.error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: cycles DataOut is held stable with Go low before each Go rise.
REQ-002 Parameter GO_HIGH_CYCLES, default 3: cycles Go is held high per operand.
REQ-003 Parameter GO_LOW_CYCLES, default 2: cycles Go is held low after each fall, DataOut unchanged.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for ResultValid (used only under the macro).
REQ-005 Clock  input  1  single clock, all state updates on rising edge.
REQ-006 Resetn  input  1  reset; one clock, reset asynchronous active-low.
REQ-007 Start  input  1  request one evaluation; sampled only in IDLE.
REQ-008 CoefA, CoefB, CoefC, CoefX  input  8 each  operands, captured on accepted Start.
REQ-009 Go  output  1  handshake strobe to the polynomial evaluator.
REQ-010 DataOut  output  8  operand presented to the evaluator's DataIn.
REQ-011 DataResult  input  8  evaluator result bus.
REQ-012 ResultValid  input  1  evaluator result qualifier.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse when Result is updated.
REQ-015 Result  output  8  captured DataResult, held until next capture.
REQ-016 Error  output  1  sticky timeout flag (macro only; tied 0 otherwise).

Function
REQ-017 States SHALL be IDLE, SETUP, GO_HI, GO_LO, WAIT_VALID, DONE; a 2-bit operand index selects A, B, C, X in that fixed order.
REQ-018 IDLE: Start=1 SHALL latch all four coefficients, clear index to 0, go to SETUP next cycle; Start=0 stays.
REQ-019 SETUP: DataOut = selected operand, Go=0, for exactly SETUP_CYCLES cycles, then GO_HI.
REQ-020 GO_HI: Go=1 for exactly GO_HIGH_CYCLES cycles, DataOut unchanged, then GO_LO.
REQ-021 GO_LO: Go=0 for exactly GO_LOW_CYCLES cycles; index<3: increment, go to SETUP; index=3: go to WAIT_VALID.
REQ-022 WAIT_VALID: first cycle with ResultValid=1 SHALL register DataResult into Result and enter DONE.
REQ-023 DONE: Done=1 for exactly one cycle, then IDLE; Busy falls with Done.
REQ-024 Start while Busy SHALL be ignored and not queued; latched coefficients SHALL not change mid-sequence.
REQ-025 DataOut SHALL be 0 in IDLE; Go SHALL never be high outside GO_HI.
REQ-026 ResultValid outside WAIT_VALID SHALL be ignored.
REQ-027 Parameters of 0 SHALL be treated as 1 (minimum one cycle per phase).
REQ-028 Total Go pulses per evaluation SHALL be exactly 4.

Reset
REQ-029 Resetn=0 SHALL immediately force IDLE, Go=0, DataOut=0, Busy=0, Done=0, Result=0, Error=0, index=0, counters 0, independent of Clock.
REQ-030 Reset mid-sequence SHALL abort without further Go pulses; operation resumes only on a new Start after release.

Configuration
REQ-031 Macro OPERAND_SEQUENCER_TIMEOUT_EN defined: WAIT_VALID counts cycles; on reaching TIMEOUT_CYCLES without ResultValid, set Error (sticky until reset or next accepted Start), leave Result unchanged, go to IDLE without Done.
REQ-032 Macro undefined: no timeout counter, WAIT_VALID waits indefinitely, Error tied 0.

Structure
REQ-033 Package operand_sequencer_pkg SHALL hold the state enumeration, operand index constants (IDX_A=0..IDX_X=3) and the 8-bit data width constant.
REQ-034 One sub-module, phase_timer: loadable down-counter with a terminal flag, shared by SETUP/GO_HI/GO_LO and the timeout.

Verification
REQ-035 A=2,B=3,C=4,X=5, Start pulse, evaluator model -> Go pulses with DataOut 2,3,4,5 in order; ResultValid with DataResult=0x45 -> Result=0x45, one Done pulse.
REQ-036 Defaults -> each Go high exactly 3 cycles, low gaps 2+2 cycles, DataOut stable 2 cycles before each rise.
REQ-037 Start re-asserted during second Go pulse with CoefA=0xFF -> ignored; sequence and Result unaffected.
REQ-038 Resetn low during third GO_HI -> Go=0, Busy=0 immediately; no further pulses; a new Start restarts from A.
REQ-039 Macro defined, ResultValid never asserted -> Error=1 after 64 WAIT_VALID cycles, IDLE, no Done; next Start clears Error.
REQ-040 ResultValid pulsed while in IDLE and during GO_HI -> Result unchanged, no Done.
